// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// branch redirect flushes, data-memory handshake with watchdog, perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifid_valid,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic [1:0]       exmem_pcsrc,
  input  logic             exmem_zero,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             redirect,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] wd, wd_next;
  logic        err_next;
  logic        memop, taken, lu, mem_stall;

  assign memop = exmem_memread | exmem_memwrite;
  assign taken = ((exmem_pcsrc == 2'b01) &  exmem_zero) |
                 ((exmem_pcsrc == 2'b10) & ~exmem_zero) |
                  (exmem_pcsrc == 2'b11);
  assign lu    = idex_memread & ifid_valid & (idex_rt != 5'd0) &
                 ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  // MEMWAIT keeps waiting on the ack regardless of the current EX/MEM contents
  assign mem_stall = ~mem_ack & (memop | (state == MEMWAIT));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    redirect     = 1'b0;
    mem_req      = 1'b0;
    state_next   = state;
    wd_next      = wd;
    err_next     = mem_err;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_next  = RUN;
      wd_next     = '0;
      err_next    = 1'b0;
    end else begin
      case (state)
        HALT: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
        end
        default: begin
          if (mem_stall) begin
            mem_req      = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            if (state != MEMWAIT) begin
              state_next = MEMWAIT;
              wd_next    = 16'd1;
            end else if (wd == WD_LIMIT) begin
              state_next = HALT;
              err_next   = 1'b1;
            end else begin
              wd_next = wd + 16'd1;
            end
          end else begin
            mem_req    = memop | (state == MEMWAIT);
            state_next = RUN;
            if (taken) begin
              redirect    = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
            end else if (lu) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state   <= state_next;
    wd      <= wd_next;
    mem_err <= err_next;
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (redirect && flush_count != '1)   flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  // {pc,ifid,idex,exmem write, ifid,idex,exmem flush, bubble, redirect, req}
  localparam logic [9:0] O_DEF   = 10'b1111_000_0_0_0;
  localparam logic [9:0] O_WAIT  = 10'b0000_000_1_0_1;
  localparam logic [9:0] O_HALT  = 10'b0000_000_1_0_0;
  localparam logic [9:0] O_LU    = 10'b0011_010_0_0_0;
  localparam logic [9:0] O_TAKEN = 10'b1111_111_0_1_0;

  logic clk = 1'b0;
  logic rst;
  logic ifid_valid, idex_memread, exmem_memread, exmem_memwrite, exmem_zero, mem_ack;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic [1:0] exmem_pcsrc;
  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, redirect, mem_req, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [9:0] outs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_pcsrc(exmem_pcsrc), .exmem_zero(exmem_zero), .mem_ack(mem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .redirect(redirect),
    .mem_req(mem_req), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_flush, exmem_flush, memwb_bubble, redirect, mem_req};

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt;
    logic       idex_mr;
    logic [4:0] idex_rt;
    logic       mr, mw;
    logic [1:0] pcsrc;
    logic       zero, ack;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic imr, input logic [4:0] irt, input logic mr,
                        input logic mw, input logic [1:0] pc, input logic z, input logic ack);
    ifid_valid = v; ifid_rs = rs; ifid_rt = rt;
    idex_memread = imr; idex_rt = irt;
    exmem_memread = mr; exmem_memwrite = mw;
    exmem_pcsrc = pc; exmem_zero = z; mem_ack = ack;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: k = index of the current MEMWAIT cycle (0 = not waiting on a prior cycle)
  int m_k, m_stall, m_flush;
  bit m_halt, m_err;

  task automatic model_clear;
    m_k = 0; m_stall = 0; m_flush = 0; m_halt = 0; m_err = 0;
  endtask

  task automatic rand_cycle;
    logic [9:0] e;
    bit memop, tk, hz, waiting, req;
    rst = ($urandom_range(0, 49) == 0);
    set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0));
    memop = exmem_memread || exmem_memwrite;
    tk = (exmem_pcsrc == 2'd1 && exmem_zero) || (exmem_pcsrc == 2'd2 && !exmem_zero) ||
         (exmem_pcsrc == 2'd3);
    hz = idex_memread && ifid_valid && idex_rt != 0 &&
         (idex_rt == ifid_rs || idex_rt == ifid_rt);
    waiting = !mem_ack && (memop || m_k > 0);
    req = memop || m_k > 0;
    if (rst)           e = '0;
    else if (m_halt)   e = O_HALT;
    else if (waiting)  e = O_WAIT;
    else if (tk)       e = O_TAKEN | 10'(req);
    else if (hz)       e = O_LU | 10'(req);
    else               e = O_DEF | 10'(req);
    @(negedge clk);
    chk("rnd_ctrl", 32'(outs), 32'(e));
    chk("rnd_stall", 32'(stall_cycles), 32'(m_stall));
    chk("rnd_flush", 32'(flush_count), 32'(m_flush));
    chk("rnd_err", 32'(mem_err), 32'(m_err));
    if (rst) begin
      model_clear();
    end else begin
      if (!e[9] && m_stall < CMAX) m_stall++;
      if (e[1] && m_flush < CMAX)  m_flush++;
      if (!m_halt) begin
        if (waiting) begin
          if (m_k == TO) begin m_halt = 1; m_err = 1; end
          else m_k++;
        end else begin
          m_k = 0;
        end
      end
    end
    tick();
  endtask

  initial begin
    //            v  rs rt imr irt mr mw pc     z  ack  exp
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, O_DEF};
    vecs[1]  = '{1, 8, 3, 1, 8, 0, 0, 2'b00, 0, 0, O_LU};
    vecs[2]  = '{1, 2, 9, 1, 9, 0, 0, 2'b00, 0, 0, O_LU};
    vecs[3]  = '{1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, O_DEF};
    vecs[4]  = '{0, 8, 3, 1, 8, 0, 0, 2'b00, 0, 0, O_DEF};
    vecs[5]  = '{1, 8, 3, 1, 8, 0, 0, 2'b01, 1, 0, O_TAKEN};
    vecs[6]  = '{1, 4, 5, 0, 4, 0, 0, 2'b01, 0, 0, O_DEF};
    vecs[7]  = '{1, 4, 5, 0, 4, 0, 0, 2'b10, 0, 0, O_TAKEN};
    vecs[8]  = '{1, 4, 5, 0, 4, 0, 0, 2'b10, 1, 0, O_DEF};
    vecs[9]  = '{1, 4, 5, 0, 4, 0, 0, 2'b11, 0, 0, O_TAKEN};
    vecs[10] = '{1, 4, 5, 0, 4, 1, 0, 2'b00, 0, 0, O_WAIT};
    vecs[11] = '{1, 4, 5, 0, 4, 0, 1, 2'b11, 0, 1, O_TAKEN | 10'd1};
    vecs[12] = '{1, 6, 5, 1, 6, 1, 0, 2'b00, 0, 1, O_LU | 10'd1};
    vecs[13] = '{1, 4, 5, 0, 4, 1, 0, 2'b11, 1, 0, O_WAIT};

    rst = 1'b1;
    set_in(1, 8, 8, 1, 8, 1, 0, 2'b11, 1, 0);
    @(negedge clk);
    chk("rst_ctrl", 32'(outs), 32'd0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("rst_ctrl_after", 32'(outs), 32'(O_DEF));
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_reset();
      set_in(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].idex_mr, vecs[i].idex_rt,
             vecs[i].mr, vecs[i].mw, vecs[i].pcsrc, vecs[i].zero, vecs[i].ack);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // load-use: one bubble, then defaults once the load leaves ID/EX
    do_reset();
    set_in(1, 8, 0, 1, 8, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("lu_stall", 32'(outs), 32'(O_LU));
    tick();
    idex_memread = 1'b0;
    @(negedge clk);
    chk("lu_release", 32'(outs), 32'(O_DEF));
    chk("lu_count", 32'(stall_cycles), 32'd1);

    // branch taken while lu true: one redirect, counted once
    do_reset();
    set_in(1, 8, 0, 1, 8, 0, 0, 2'b01, 1, 0);
    @(negedge clk);
    chk("br_taken", 32'(outs), 32'(O_TAKEN));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("br_after", 32'(outs), 32'(O_DEF));
    chk("br_count", 32'(flush_count), 32'd1);
    chk("br_nostall", 32'(stall_cycles), 32'd0);

    // load acked 3 cycles late
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("dly_wait%0d", i), 32'(outs), 32'(O_WAIT));
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("dly_ack", 32'(outs), 32'(O_DEF | 10'd1));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("dly_run", 32'(outs), 32'(O_DEF));
    chk("dly_count", 32'(stall_cycles), 32'd3);

    // single-cycle memory: no stall
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1);
    @(negedge clk);
    chk("fast_ack", 32'(outs), 32'(O_DEF | 10'd1));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("fast_count", 32'(stall_cycles), 32'd0);

    // watchdog: entry cycle plus TO MEMWAIT cycles, then HALT
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk);
      chk($sformatf("wd_wait%0d", i), 32'(outs), 32'(O_WAIT));
      chk($sformatf("wd_noerr%0d", i), 32'(mem_err), 32'd0);
      tick();
    end
    set_in(1, 8, 8, 1, 8, 1, 1, 2'b11, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("halt%0d", i), 32'(outs), 32'(O_HALT));
      chk($sformatf("halt_err%0d", i), 32'(mem_err), 32'd1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("halt_rst_ctrl", 32'(outs), 32'd0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("halt_rst_err", 32'(mem_err), 32'd0);
    chk("halt_rst_run", 32'(outs), 32'(O_DEF));

    // flush_count saturation
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0);
    for (int i = 0; i < 70000; i++) begin
      if (i == CMAX - 1) begin
        @(negedge clk);
        chk("sat_pre", 32'(flush_count), 32'(CMAX - 1));
      end
      tick();
    end
    @(negedge clk);
    chk("sat_flush", 32'(flush_count), 32'(CMAX));
    chk("sat_redirect", 32'(outs), 32'(O_TAKEN));
    chk("sat_stall", 32'(stall_cycles), 32'd0);

    // randomized traffic against the model
    do_reset();
    model_clear();
    for (int n = 0; n < 4000; n++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined MIPS core. It watches the IF/ID, ID/EX and EX/MEM pipeline registers and drives every pipeline-register enable and flush. It also drives the PC write enable and the branch redirect select. It handles three events: load-use hazards, branch/jump resolution in MEM, and a req/ack handshake to a multi-cycle data memory, with a watchdog that halts the core on a lost ack. Two saturating performance counters are included.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in MEMWAIT before the error halt; legal range 1..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ifid_valid  in  1  IF/ID holds a real instruction
- ifid_rs  in  5  inst[25:21] in IF/ID
- ifid_rt  in  5  inst[20:16] in IF/ID
- idex_memread  in  1  ID/EX MEM-control MemRead
- idex_rt  in  5  destination register of the load in ID/EX
- exmem_memread  in  1  EX/MEM MemRead
- exmem_memwrite  in  1  EX/MEM MemWrite
- exmem_pcsrc  in  2  EX/MEM PCSrc: 00 none, 01 beq, 10 bne, 11 jump
- exmem_zero  in  1  EX/MEM zero flag
- mem_ack  in  1  data memory completes the current access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load zeros (bubble) at the next edge
- memwb_bubble  out  1  MEM/WB loads a bubble at the next edge
- redirect  out  1  PC mux selects the EX/MEM add result
- mem_req  out  1  data-memory request
- mem_err  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0 while not in reset
- flush_count  out  CNT_W  saturating count of taken redirects

## Operation
- States: RUN, MEMWAIT, HALT. Reset state is RUN.
- Derived signals (combinational):
  - memop = exmem_memread | exmem_memwrite
  - taken = (pcsrc==01 & zero) | (pcsrc==10 & !zero) | pcsrc==11
  - lu = idex_memread & ifid_valid & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)
- Default outputs: all write enables 1; all flushes, memwb_bubble, redirect and mem_req 0.
- Priority, highest first: HALT > memory wait > taken > lu.
- Memory wait (RUN with memop and !mem_ack, or MEMWAIT with !mem_ack):
  - mem_req=1; pc/ifid/idex/exmem_write=0; memwb_bubble=1; no flushes; no redirect.
  - RUN goes to MEMWAIT. A watchdog counter loads 1 on entry and increments each MEMWAIT cycle.
- Access completes (memop & mem_ack in RUN, or mem_ack in MEMWAIT):
  - mem_req=1 and the pipeline advances normally in that cycle. taken and lu are then evaluated in the same cycle.
  - MEMWAIT returns to RUN.
- taken (not waiting): redirect=1; ifid_flush=idex_flush=exmem_flush=1; all writes 1; flush_count+1. lu is ignored.
- lu (not waiting, not taken): pc_write=0; ifid_write=0; idex_flush=1. Exactly one bubble is inserted; lu clears on the next cycle when the load leaves ID/EX.
- Watchdog: in MEMWAIT with !mem_ack and watchdog==TIMEOUT, go to HALT and set mem_err.
- HALT: all write enables 0; memwb_bubble=1; mem_req=0; no flushes. HALT exits only through rst.
- Counters saturate at all-ones and do not wrap.

## Timing
- Control outputs are combinational from state and inputs, valid in the same cycle. Pipeline registers act on them at the next edge.
- State, watchdog, mem_err and both counters are registered.
- While rst=1:
  - All write enables are 0; all flush, bubble, redirect and mem_req outputs are 0.
  - On the edge, state=RUN, watchdog=0, mem_err=0, counters=0.
- rst asserted in MEMWAIT or HALT abandons the access; mem_req drops in the rst cycle.
- Single-cycle memory (ack in the same cycle as req): zero stall cycles.
- An access acked after N extra cycles costs exactly N stall cycles.
- Branch penalty: 3 flushed slots; redirect is high for exactly one cycle.
- Load-use penalty: 1 cycle.

## Test plan
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8, ifid_valid=1 → one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle defaults; stall_cycles=1.
- idex_rt=0 with ifid_rs=0 and idex_memread=1 → no stall.
- beq taken (pcsrc=01, zero=1) while lu is also true → redirect=1, three flushes, pc_write=1, flush_count=1. With pcsrc=01, zero=0 → no redirect.
- Load in EX/MEM, mem_ack delayed 3 cycles → 3 cycles with mem_req=1, all writes 0, memwb_bubble=1; advance on the ack cycle; stall_cycles=3; state back in RUN.
- TIMEOUT=4, mem_ack never asserted → mem_err=1 after the 4th MEMWAIT cycle; HALT holds all enables 0 indefinitely; rst clears mem_err and returns to RUN.
- Drive 70000 taken branches with CNT_W=16 → flush_count saturates at 65535.
